// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program-counter unit.
package pc_pkg;

  localparam int unsigned STALL_W         = 6;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
  localparam int unsigned DEF_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_FLUSH  = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_PEND   = 3'd2,
    SEL_SEQ    = 3'd3,
    SEL_HOLD   = 3'd4
  } pc_sel_t;

endpackage

// File: rtl/pc_if.sv
// Fetch-side bus between the PC unit and its neighbours (ID, CP0, imem).
interface pc_if #(
  parameter int unsigned ADDR_W = 32
);

  logic [pc_pkg::STALL_W-1:0] stall;
  logic                       ifAck_i;
  logic                       branchEnable_i;
  logic [ADDR_W-1:0]          branchAddr_i;
  logic                       flush_i;
  logic [ADDR_W-1:0]          flushAddr_i;
  logic [ADDR_W-1:0]          pc_o;
  logic                       ifReq_o;
  logic                       pendValid_o;
  logic                       misalign_o;

  modport master (
    input  stall, ifAck_i, branchEnable_i, branchAddr_i, flush_i, flushAddr_i,
    output pc_o, ifReq_o, pendValid_o, misalign_o
  );

  modport slave (
    output stall, ifAck_i, branchEnable_i, branchAddr_i, flush_i, flushAddr_i,
    input  pc_o, ifReq_o, pendValid_o, misalign_o
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder: flush > branch > pending > sequential > hold.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  pc_state_t         state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              stall_if,
  input  logic              ack,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output pc_sel_t           sel_c,
  output logic [ADDR_W-1:0] next_pc_c
);

  // The first edge out of BOOT honours only a flush.
  always_comb begin
    sel_c = SEL_HOLD;
    if (flush) begin
      sel_c = SEL_FLUSH;
    end else if (state != BOOT && !stall_if) begin
      if (branch_en)       sel_c = SEL_BRANCH;
      else if (pend_valid) sel_c = SEL_PEND;
      else if (ack)        sel_c = SEL_SEQ;
    end
  end

  always_comb begin
    next_pc_c = pc;
    case (sel_c)
      SEL_FLUSH:  next_pc_c = flush_addr;
      SEL_BRANCH: next_pc_c = branch_addr;
      SEL_PEND:   next_pc_c = pend_addr;
      SEL_SEQ:    next_pc_c = pc + ADDR_W'(INSTR_BYTES);
      default:    next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with fetch handshake, flush and a held redirect
// for branches that resolve while IF is stalled.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
  parameter int unsigned       INSTR_BYTES = DEF_INSTR_BYTES
) (
  input logic   clk,
  input logic   rst_n,
  pc_if.master  bus
);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic              req_q, req_d;
  logic              mis_q, mis_d;
  pc_sel_t           sel_c;
  logic [ADDR_W-1:0] next_pc_c;
  logic              stall_if;
  logic              stall_unused;

  assign stall_if     = bus.stall[0];
  assign stall_unused = ^bus.stall[STALL_W-1:1];

  pc_next_sel #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .state       (state_q),
    .pc          (pc_q),
    .pend_valid  (pend_valid_q),
    .pend_addr   (pend_addr_q),
    .stall_if    (stall_if),
    .ack         (bus.ifAck_i),
    .branch_en   (bus.branchEnable_i),
    .branch_addr (bus.branchAddr_i),
    .flush       (bus.flush_i),
    .flush_addr  (bus.flushAddr_i),
    .sel_c       (sel_c),
    .next_pc_c   (next_pc_c)
  );

  // Next state, pending-redirect capture and output decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = next_pc_c;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (sel_c == SEL_FLUSH || sel_c == SEL_BRANCH || sel_c == SEL_PEND) begin
          pend_valid_d = 1'b0;
          state_d      = RUN;
        end else if (bus.branchEnable_i && stall_if) begin
          // Last branch seen under stall wins.
          pend_addr_d  = bus.branchAddr_i;
          pend_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      default: state_d = BOOT;
    endcase
    req_d = (state_d != BOOT);
    mis_d = req_d && (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      req_q        <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      req_q        <= req_d;
      mis_q        <= mis_d;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.ifReq_o     = req_q;
  assign bus.pendValid_o = pend_valid_q;
  assign bus.misalign_o  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: 32-bit and 16-bit instances share one directed stimulus
// and are checked each cycle against a rule-level reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall = '0;
  logic        ack = 1'b0, br = 1'b0, fl = 1'b0;
  logic [31:0] ba = '0, fa = '0;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  localparam logic [15:0] RV16 = 16'h0010;

  always #5 clk = ~clk;

  pc_if #(.ADDR_W(32)) if32 ();
  pc_if #(.ADDR_W(16)) if16 ();

  assign if32.stall = stall;          assign if16.stall = stall;
  assign if32.ifAck_i = ack;          assign if16.ifAck_i = ack;
  assign if32.branchEnable_i = br;    assign if16.branchEnable_i = br;
  assign if32.branchAddr_i = ba;      assign if16.branchAddr_i = ba[15:0];
  assign if32.flush_i = fl;           assign if16.flush_i = fl;
  assign if32.flushAddr_i = fa;       assign if16.flushAddr_i = fa[15:0];

  pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .INSTR_BYTES(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.master));
  pc_unit #(.ADDR_W(16), .RESET_VEC(RV16), .INSTR_BYTES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.master));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pa;
    bit          pv;
    bit          boot;
  } mdl_t;

  mdl_t m32, m16;

  function automatic mdl_t mreset(logic [31:0] rv);
    mdl_t r;
    r.pc = rv; r.pa = '0; r.pv = 1'b0; r.boot = 1'b1;
    return r;
  endfunction

  // One clock of the spec's priority rules on a model of the given width mask.
  function automatic mdl_t mstep(mdl_t m, logic [31:0] mask);
    mdl_t r = m;
    if (m.boot) begin
      r.boot = 1'b0;
      if (fl) r.pc = fa & mask;
    end else if (fl) begin
      r.pc = fa & mask; r.pv = 1'b0;
    end else if (stall[0]) begin
      if (br) begin r.pa = ba & mask; r.pv = 1'b1; end
    end else if (br) begin
      r.pc = ba & mask; r.pv = 1'b0;
    end else if (m.pv) begin
      r.pc = m.pa; r.pv = 1'b0;
    end else if (ack) begin
      r.pc = (m.pc + 32'd4) & mask;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m32 <= mreset(32'h0);
      m16 <= mreset({16'h0, RV16});
    end else begin
      m32 <= mstep(m32, 32'hFFFF_FFFF);
      m16 <= mstep(m16, 32'h0000_FFFF);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("pc32",   if32.pc_o, m32.pc);
      chk("req32",  32'(if32.ifReq_o), 32'(!m32.boot));
      chk("pend32", 32'(if32.pendValid_o), 32'(m32.pv));
      chk("mis32",  32'(if32.misalign_o), 32'(!m32.boot && m32.pc[1:0] != 2'b00));
      chk("pc16",   32'(if16.pc_o), m16.pc);
      chk("req16",  32'(if16.ifReq_o), 32'(!m16.boot));
      chk("pend16", 32'(if16.pendValid_o), 32'(m16.pv));
      chk("mis16",  32'(if16.misalign_o), 32'(!m16.boot && m16.pc[1:0] != 2'b00));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    started = 1'b1;
    chk("lit_rst_pc", if32.pc_o, 32'h0);
    chk("lit_rst_req", 32'(if32.ifReq_o), 32'h0);
    chk("lit_rst_pc16", 32'(if16.pc_o), 32'h10);

    // Release with ack held: 0, 0, 4, 8, 12.
    rst_n = 1'b1; ack = 1'b1;
    cyc(1);
    chk("lit_boot_pc", if32.pc_o, 32'h0);
    chk("lit_boot_req", 32'(if32.ifReq_o), 32'h1);
    cyc(3);
    chk("lit_seq_pc", if32.pc_o, 32'hC);

    // Two branches under stall: last one wins on release.
    stall = 6'h01; br = 1'b1; ba = 32'h100;
    cyc(1);
    ba = 32'h200;
    cyc(1);
    br = 1'b0;
    cyc(1);
    chk("lit_hold_pc", if32.pc_o, 32'hC);
    chk("lit_hold_pv", 32'(if32.pendValid_o), 32'h1);
    stall = 6'h3E;
    cyc(1);
    chk("lit_rel_pc", if32.pc_o, 32'h200);
    cyc(1);
    chk("lit_rel_seq", if32.pc_o, 32'h204);

    // Flush beats a simultaneous stalled branch and a pending redirect.
    stall = 6'h01; br = 1'b1; ba = 32'h300;
    cyc(1);
    fl = 1'b1; fa = 32'h80; ba = 32'h100;
    cyc(1);
    chk("lit_flush_pc", if32.pc_o, 32'h80);
    chk("lit_flush_pv", 32'(if32.pendValid_o), 32'h0);
    fl = 1'b0; br = 1'b0; stall = '0;
    cyc(1);
    chk("lit_flush_seq", if32.pc_o, 32'h84);

    // No ack: hold; a branch redirects without ack.
    ack = 1'b0;
    cyc(4);
    chk("lit_noack_pc", if32.pc_o, 32'h84);
    br = 1'b1; ba = 32'h40;
    cyc(1);
    chk("lit_br_noack", if32.pc_o, 32'h40);

    // Wrap and misalignment.
    ba = 32'h0000_FFFC;
    cyc(1);
    br = 1'b0; ack = 1'b1;
    cyc(1);
    chk("lit_wrap16", 32'(if16.pc_o), 32'h0);
    chk("lit_nowrap32", if32.pc_o, 32'h1_0000);
    ack = 1'b0; br = 1'b1; ba = 32'h0102;
    cyc(1);
    chk("lit_mis16", 32'(if16.misalign_o), 32'h1);
    chk("lit_mis32", 32'(if32.misalign_o), 32'h1);
    ba = 32'hFFFF_FFFC;
    cyc(1);
    br = 1'b0; ack = 1'b1;
    cyc(1);
    chk("lit_wrap32", if32.pc_o, 32'h0);

    // Async reset mid-HOLD drops the pending redirect.
    ack = 1'b0; stall = 6'h01; br = 1'b1; ba = 32'h500;
    cyc(1);
    br = 1'b0;
    chk("lit_pend500", 32'(if32.pendValid_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_pc", if32.pc_o, 32'h0);
    chk("lit_arst_pc16", 32'(if16.pc_o), 32'h10);
    chk("lit_arst_pv", 32'(if32.pendValid_o), 32'h0);
    cyc(1);
    // Redirects and ack in the BOOT cycle are ignored.
    rst_n = 1'b1; stall = '0; br = 1'b1; ba = 32'h700; ack = 1'b1;
    cyc(1);
    chk("lit_boot_ign", if32.pc_o, 32'h0);
    br = 1'b0; ack = 1'b0;
    cyc(1);
    chk("lit_no500", if32.pc_o, 32'h0);

    // Flush is honoured in the BOOT cycle.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1; fl = 1'b1; fa = 32'h60;
    cyc(1);
    chk("lit_boot_flush", if32.pc_o, 32'h60);
    chk("lit_boot_flush16", 32'(if16.pc_o), 32'h60);
    fl = 1'b0;
    cyc(2);

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the IF stage; the next generation of the fetch PC register. It adds over the plain PC register:
- configurable address width and reset vector;
- fetch valid/ack handshake;
- exception flush with top priority;
- a pending-redirect register, so a branch resolved while IF is stalled is held until the stall releases.

It drives the instruction-memory address and receives redirects from ID (branch) and the exception/CP0 logic (flush).

## Interface
Parameters:
- ADDR_W, 32, PC / address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded by reset (ADDR_W bits).
- INSTR_BYTES, 4, sequential increment.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  6  pipeline stall vector; only bit 0 (IF) is used here.
- ifAck_i  in  1  instruction memory accepted the current pc_o this cycle.
- branchEnable_i  in  1  branch/jump taken, resolved in ID.
- branchAddr_i  in  ADDR_W  branch target.
- flush_i  in  1  exception/ERET redirect.
- flushAddr_i  in  ADDR_W  handler or EPC target.
- pc_o  out  ADDR_W  fetch address.
- ifReq_o  out  1  pc_o is a valid fetch request.
- pendValid_o  out  1  a held redirect is waiting.
- misalign_o  out  1  pc_o[1:0] != 0 while ifReq_o=1 (drives AdEL in CP0).

## Operation
- FSM states (pc_pkg::pc_state_t):
  - BOOT: after reset.
  - RUN: fetching.
  - HOLD: stalled with a redirect latched.
- Next-PC priority, highest first:
  1. flush_i: ignores stall and ack; clears pending; state goes to RUN.
  2. branchEnable_i with stall[0]=0: loads branchAddr_i; clears pending.
  3. pending redirect with stall[0]=0: loads pendAddr; clears pending.
  4. Sequential: when stall[0]=0 and ifAck_i=1, pc_o <= pc_o + INSTR_BYTES.
  5. Otherwise hold.
- branchEnable_i with stall[0]=1: pendAddr <= branchAddr_i, pendValid <= 1, state goes to HOLD, pc_o unchanged. A later branch arriving in HOLD overwrites pendAddr (last writer wins).
- Redirects do not require ifAck_i. An unacknowledged request at the old address is abandoned.
- BOOT goes to RUN on the first clock edge after rst_n deasserts. pc_o stays RESET_VEC. Any redirect or ack in that cycle is ignored, except flush_i, which is applied.
- ifReq_o = 1 in RUN and HOLD, 0 in BOOT.
- Arithmetic: all adds are modulo 2^ADDR_W. All-ones minus 3 plus 4 wraps to 0 with no flag. Targets are used unmodified; misalignment is only flagged.

## Timing
- Reset, asynchronous: pc_o=RESET_VEC, state=BOOT, ifReq_o=0, pendValid_o=0, pendAddr=0, misalign_o=RESET_VEC[1:0]!=0 gated by ifReq_o, i.e. 0.
- Redirect latency: target appears on pc_o one cycle after flush_i or an unstalled branchEnable_i.
- Held redirect: appears on pc_o on the first edge where stall[0]=0.
- Outputs pc_o, pendValid_o and state are registered. ifReq_o and misalign_o are decoded from registered state only, with no input-to-output combinational path.
- flush_i and branchEnable_i in the same cycle: flush wins and the branch is dropped.
- Reset asserted mid-HOLD: pending is lost and the PC returns to RESET_VEC immediately.

## Structure
- Package pc_pkg holds:
  - pc_state_t enum {BOOT, RUN, HOLD};
  - the next-PC select enum {SEL_FLUSH, SEL_BRANCH, SEL_PEND, SEL_SEQ, SEL_HOLD};
  - default RESET_VEC and INSTR_BYTES constants.
- One combinational sub-module, pc_next_sel, implements the priority encoder and returns the select plus next PC. pc_unit holds the registers and the FSM.

## Test plan
- Reset then release with ifAck_i=1: pc_o=0 for 2 cycles (BOOT, then first RUN fetch), then 4, 8, 12; ifReq_o rises 1 cycle after release.
- stall[0]=1 for 3 cycles, with branch to 0x100 in cycle 1 and 0x200 in cycle 2: pendValid_o=1, pc_o frozen; on release pc_o=0x200, then 0x204.
- flush_i to 0x80 in the same cycle as branchEnable_i to 0x100 under stall, with pending 0x300: next pc_o=0x80, pendValid_o=0.
- ifAck_i=0 for 4 cycles with no stall: pc_o holds. A branch to 0x40 during the wait loads 0x40 the next cycle without ack.
- ADDR_W=16, pc=0xFFFC, ack: pc_o=0x0000. Branch to 0x0102: misalign_o=1 the next cycle.
- rst_n asserted mid-HOLD (pending 0x500): pc_o=RESET_VEC asynchronously, pendValid_o=0; after release no jump to 0x500.
